// File: rtl/fsm_estacionamiento.sv
// Parking-lot gate controller: decodes an outer/inner beam pair (A outside,
// B inside) into entry/exit events, keeps the occupancy count and flags
// physically impossible sensor sequences.
module fsm_estacionamiento #(
    parameter int unsigned CAPACITY = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       sensor,
    output logic             entrada,
    output logic             salida,
    output logic [CNT_W-1:0] ocupados,
    output logic             lleno,
    output logic             error
);

    // Beam patterns: bit1 = A (outside) blocked, bit0 = B (inside) blocked.
    localparam logic [1:0] SNS_NONE = 2'b00;
    localparam logic [1:0] SNS_A    = 2'b10;
    localparam logic [1:0] SNS_AB   = 2'b11;
    localparam logic [1:0] SNS_B    = 2'b01;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        E_A   = 3'd1,
        E_AB  = 3'd2,
        E_B   = 3'd3,
        S_B   = 3'd4,
        S_AB  = 3'd5,
        S_A   = 3'd6,
        ERROR = 3'd7
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   entry_c;
    logic   exit_c;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; each state's own sensor pattern holds it by default.
    always_comb begin
        state_nxt = state;
        entry_c   = 1'b0;
        exit_c    = 1'b0;
        unique case (state)
            IDLE: begin
                case (sensor)
                    SNS_A:   state_nxt = E_A;
                    SNS_B:   state_nxt = S_B;
                    SNS_AB:  state_nxt = ERROR;
                    default: state_nxt = IDLE;
                endcase
            end
            E_A: begin
                case (sensor)
                    SNS_AB:   state_nxt = E_AB;
                    SNS_NONE: state_nxt = IDLE;   // car backed off
                    SNS_B:    state_nxt = ERROR;
                    default:  state_nxt = E_A;
                endcase
            end
            E_AB: begin
                case (sensor)
                    SNS_B:    state_nxt = E_B;
                    SNS_A:    state_nxt = E_A;    // reversal
                    SNS_NONE: state_nxt = ERROR;
                    default:  state_nxt = E_AB;
                endcase
            end
            E_B: begin
                case (sensor)
                    SNS_NONE: begin
                        state_nxt = IDLE;
                        entry_c   = 1'b1;
                    end
                    SNS_AB:  state_nxt = E_AB;    // reversal
                    SNS_A:   state_nxt = ERROR;
                    default: state_nxt = E_B;
                endcase
            end
            S_B: begin
                case (sensor)
                    SNS_AB:   state_nxt = S_AB;
                    SNS_NONE: state_nxt = IDLE;   // car backed off
                    SNS_A:    state_nxt = ERROR;
                    default:  state_nxt = S_B;
                endcase
            end
            S_AB: begin
                case (sensor)
                    SNS_A:    state_nxt = S_A;
                    SNS_B:    state_nxt = S_B;    // reversal
                    SNS_NONE: state_nxt = ERROR;
                    default:  state_nxt = S_AB;
                endcase
            end
            S_A: begin
                case (sensor)
                    SNS_NONE: begin
                        state_nxt = IDLE;
                        exit_c    = 1'b1;
                    end
                    SNS_AB:  state_nxt = S_AB;    // reversal
                    SNS_B:   state_nxt = ERROR;
                    default: state_nxt = S_A;
                endcase
            end
            ERROR: begin
                if (sensor == SNS_NONE) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One-cycle event pulses and error flag, aligned with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entrada <= 1'b0;
            salida  <= 1'b0;
            error   <= 1'b0;
        end else begin
            entrada <= entry_c;
            salida  <= exit_c;
            error   <= (state_nxt == ERROR);
        end
    end

    // Occupancy counter, saturating at both ends; pulses still fire when saturated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ocupados <= CNT_ZERO;
        end else if (entry_c) begin
            if (ocupados < CNT_MAX) begin
                ocupados <= ocupados + CNT_ONE;
            end
        end else if (exit_c) begin
            if (ocupados != CNT_ZERO) begin
                ocupados <= ocupados - CNT_ONE;
            end
        end
    end

    // Full flag straight from the count.
    assign lleno = (ocupados == CNT_MAX);

endmodule

// File: tb/tb_fsm_estacionamiento.sv
// Bench for fsm_estacionamiento: stimulus drives beam patterns and pushes the
// expected post-edge outputs; a monitor pops and compares them.
// The reference treats the beams as a Gray-code walk away from 00: a 2-bit jump
// is impossible, and a return to 00 counts a passage only if the car left on
// the opposite beam from the one it arrived on.
module tb_fsm_estacionamiento;

    localparam int unsigned CAP = 2;
    localparam int unsigned CW  = 3;

    logic          clk    = 1'b0;
    logic          reset  = 1'b0;
    logic [1:0]    sensor = 2'b00;
    logic          entrada;
    logic          salida;
    logic [CW-1:0] ocupados;
    logic          lleno;
    logic          error;

    fsm_estacionamiento #(.CAPACITY(CAP), .CNT_W(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .sensor   (sensor),
        .entrada  (entrada),
        .salida   (salida),
        .ocupados (ocupados),
        .lleno    (lleno),
        .error    (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          ent;
        logic          sal;
        logic [CW-1:0] occ;
        logic          full;
        logic          err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    // Reference state: occupancy, impossible-sequence flag, current beam
    // pattern on the walk and the pattern the walk started with.
    int         m_occ   = 0;
    bit         m_err   = 1'b0;
    logic [1:0] m_pos   = 2'b00;
    logic [1:0] m_first = 2'b00;

    function automatic exp_t snap(input bit ent, input bit sal);
        exp_t e;
        e.ent  = ent;
        e.sal  = sal;
        e.occ  = CW'(m_occ);
        e.full = (m_occ == CAP);
        e.err  = m_err;
        return e;
    endfunction

    task automatic model_reset();
        m_occ   = 0;
        m_err   = 1'b0;
        m_pos   = 2'b00;
        m_first = 2'b00;
        q.push_back(snap(1'b0, 1'b0));
    endtask

    task automatic model_step(input logic [1:0] s);
        bit ent = 1'b0;
        bit sal = 1'b0;
        if (m_err) begin
            if (s == 2'b00) begin
                m_err = 1'b0;
                m_pos = 2'b00;
            end
        end else if ((m_pos ^ s) == 2'b11) begin
            m_err = 1'b1;
        end else if (m_pos == 2'b00 && s != 2'b00) begin
            m_first = s;
            m_pos   = s;
        end else if (m_pos != 2'b00 && s == 2'b00) begin
            if (m_pos != m_first) begin
                if (m_first == 2'b10) begin
                    ent = 1'b1;
                    if (m_occ < CAP) m_occ++;
                end else begin
                    sal = 1'b1;
                    if (m_occ > 0) m_occ--;
                end
            end
            m_pos = 2'b00;
        end else begin
            m_pos = s;
        end
        q.push_back(snap(ent, sal));
    endtask

    task automatic drive(input logic [1:0] s);
        sensor = s;
        model_step(s);
    endtask

    task automatic step(input logic [1:0] s);
        @(negedge clk);
        drive(s);
        @(posedge clk);
    endtask

    // Apply n patterns, first pattern in the top two bits of v.
    task automatic seq(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            step(v[15-2*i -: 2]);
        end
    endtask

    // Asynchronous reset landing between clock edges; released with 00 applied.
    task automatic mid_reset();
        #3;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(2'b00);
        @(posedge clk);
    endtask

    // Stimulus: directed scenarios, then a biased random walk.
    initial begin
        logic [1:0] s;
        int         r;
        #2;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive(2'b00);
        @(posedge clk);

        seq(16'b00_10_11_01_00_000000, 5);        // entry, 0 -> 1
        mid_reset();                              // lands on the entrada pulse
        seq(16'b10_11_01_00_00000000, 4);         // entry, 0 -> 1
        seq(16'b01_11_10_00_00000000, 4);         // exit, 1 -> 0
        seq(16'b01_11_10_00_00000000, 4);         // exit at 0, stays 0
        seq(16'b10_11_10_00_00000000, 4);         // reversal, no pulse
        seq(16'b10_11_01_11_01_00_0000, 6);       // one entry after reversal
        seq(16'b00_11_10_10_00_000000, 5);        // 00->11 error, hold, clear
        seq(16'b10_01_01_00_00000000, 4);         // 10->01 error
        seq(16'b00_11_10_0000000000, 3);
        mid_reset();                              // reset while in error
        for (int k = 0; k < 3; k++) seq(16'b10_11_01_00_00000000, 4);
        seq(16'b01_11_10_00_00000000, 4);         // 2 -> 1, lleno drops
        seq(16'b10_10_11_11_01_01_00_00, 8);      // multi-cycle holds

        s = 2'b00;
        for (int i = 0; i < 2000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8)       s = 2'($urandom_range(0, 3));
            else if (r < 35) s = s;
            else if (r < 65) s = s ^ 2'b10;
            else             s = s ^ 2'b01;
            step(s);
            if ($urandom_range(0, 299) == 0) begin
                mid_reset();
                s = 2'b00;
            end
        end
        repeat (3) step(2'b00);
        done = 1'b1;
    end

    // Monitor: pops one expectation per clock edge or reset assertion.
    initial begin
        exp_t e;
        exp_t a;
        int   cyc = 0;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{entrada, salida, ocupados, lleno, error};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got ent=%0b sal=%0b occ=%0d full=%0b err=%0b want ent=%0b sal=%0b occ=%0d full=%0b err=%0b",
                             $time, a.ent, a.sal, a.occ, a.full, a.err,
                             e.ent, e.sal, e.occ, e.full, e.err);
                end
            end
            if (done || cyc > 20000) begin
                checks++;
                if (!done) begin
                    errors++;
                    $display("FAIL timeout cycles=%0d required stimulus end", cyc);
                end else if (q.size() != 0) begin
                    errors++;
                    $display("FAIL drain pending=%0d required 0", q.size());
                end
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

endmodule
